// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared types and helpers for the synchronous FIFO read/write controllers.
package sfifo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } rd_state_t;

   localparam int DEF_ADDR_W = 8;
   localparam int DEPTH      = 2**DEF_ADDR_W;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptrWidth(input int addrW);
      return addrW + 1;
   endfunction

endpackage

// File: rtl/sfifo_rd_ctrl_if.sv
// sfifo_rd_ctrl_if: read-side bundle between the FIFO read controller, RAM, writer and consumer.
interface sfifo_rd_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              rd_req;
   logic [ADDR_W:0]   wr_ptr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W:0]   rd_ptr;
   logic              empty;
   logic              almost_empty;
   logic [ADDR_W:0]   level;
   logic              dout_valid;
   logic              underflow;

   modport master (
      input  rd_req, wr_ptr,
      output rd_en, rd_addr, rd_ptr, empty, almost_empty, level, dout_valid, underflow
   );

   modport slave (
      output rd_req, wr_ptr,
      input  rd_en, rd_addr, rd_ptr, empty, almost_empty, level, dout_valid, underflow
   );
endinterface

// File: rtl/sfifo_ptr_cnt.sv
// sfifo_ptr_cnt: ADDR_W+1-bit FIFO pointer with increment enable; shared by read and write sides.
module sfifo_ptr_cnt
   import sfifo_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        inc,
   output logic [ptrWidth(ADDR_W)-1:0] ptr
);
   localparam int PW = ptrWidth(ADDR_W);

   // NOTE: state flops use non-blocking assignments and list the async reset in the sensitivity list.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    ptr <= '0;
      else if (inc) ptr <= ptr + PW'(1);
   end

endmodule

// File: rtl/sfifo_rd_ctrl.sv
// sfifo_rd_ctrl: FIFO read controller, standard or first-word-fall-through, with level and almost-empty.
// Define SFIFO_RD_UNDERFLOW_EN to build the sticky underflow flag; otherwise underflow is tied low.
module sfifo_rd_ctrl
   import sfifo_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter bit FWFT      = 1'b0,
   parameter int AE_THRESH = 1
) (
   input logic             clk,
   input logic             reset,
   sfifo_rd_ctrl_if.master bus
);
   localparam int            PW       = ptrWidth(ADDR_W);
   localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

   logic [PW-1:0]     rdPtr;
   logic [PW-1:0]     wrPtr;
   logic [PW-1:0]     level;
   logic [ADDR_W-1:0] rdAddr;
   logic              rdReq;
   logic              rdEn;
   logic              popRd;
   logic              doutValid;
   logic              isEmpty;

   assign rdReq = bus.rd_req;
   assign wrPtr = bus.wr_ptr;

   // Committed pointer: the writer only sees words the consumer has really taken.
   sfifo_ptr_cnt #(.ADDR_W(ADDR_W)) rdPtrCnt (
      .clk   (clk),
      .reset (reset),
      .inc   (popRd),
      .ptr   (rdPtr)
   );

   assign level = wrPtr - rdPtr;

   generate
      if (FWFT == 1'b0) begin : gStd
         logic validQ;

         assign isEmpty = (wrPtr == rdPtr);
         assign rdEn    = rdReq && !isEmpty;
         assign popRd   = rdEn;
         assign rdAddr  = rdPtr[ADDR_W-1:0];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) validQ <= 1'b0;
            else       validQ <= rdEn;
         end

         assign doutValid = validQ;
      end else begin : gFwft
         rd_state_t     state;
         rd_state_t     nextState;
         logic [PW-1:0] fetchPtr;
         logic          fetch;
         logic          pop;

         // Prefetch pointer runs at most one word ahead of rdPtr.
         sfifo_ptr_cnt #(.ADDR_W(ADDR_W)) fetchPtrCnt (
            .clk   (clk),
            .reset (reset),
            .inc   (fetch),
            .ptr   (fetchPtr)
         );

         always_ff @(posedge clk or posedge reset) begin
            if (reset) state <= IDLE;
            else       state <= nextState;
         end

         // NOTE: every combinational output gets a default first so no latch is inferred.
         always_comb begin
            nextState = state;
            case (state)
               IDLE:    if (fetch)         nextState = VALID;
               VALID:   if (pop && !fetch) nextState = IDLE;
               default:                    nextState = IDLE;
            endcase
         end

         always_comb begin
            doutValid = (state == VALID);
            pop       = rdReq && (state == VALID);
            fetch     = (fetchPtr != wrPtr) && ((state == IDLE) || pop);
         end

         assign isEmpty = !doutValid;
         assign rdEn    = fetch;
         assign popRd   = pop;
         assign rdAddr  = fetchPtr[ADDR_W-1:0];
      end
   endgenerate

`ifdef SFIFO_RD_UNDERFLOW_EN
   logic underflowQ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 underflowQ <= 1'b0;
      else if (rdReq && isEmpty) underflowQ <= 1'b1;
   end

   assign bus.underflow = underflowQ;
`else
   assign bus.underflow = 1'b0;
`endif

   assign bus.rd_en        = rdEn;
   assign bus.rd_addr      = rdAddr;
   assign bus.rd_ptr       = rdPtr;
   assign bus.empty        = isEmpty;
   assign bus.almost_empty = (level <= AE_LIMIT);
   assign bus.level        = level;
   assign bus.dout_valid   = doutValid;

endmodule

// File: tb/tb_sfifo_rd_ctrl.sv
// tb_sfifo_rd_ctrl: directed bench for standard and FWFT read controllers side by side, with RAM model
// and data scoreboards. Underflow expectations follow SFIFO_RD_UNDERFLOW_EN.
module tb_sfifo_rd_ctrl;
   localparam int AW = 2;
`ifdef SFIFO_RD_UNDERFLOW_EN
   localparam logic UF_EXP = 1'b1;
`else
   localparam logic UF_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   nVec = 0;
   int   nErr = 0;

   sfifo_rd_ctrl_if #(.ADDR_W(AW)) busS ();
   sfifo_rd_ctrl_if #(.ADDR_W(AW)) busF ();

   sfifo_rd_ctrl #(.ADDR_W(AW), .FWFT(1'b0), .AE_THRESH(1)) dutS (
      .clk   (clk),
      .reset (reset),
      .bus   (busS)
   );

   sfifo_rd_ctrl #(.ADDR_W(AW), .FWFT(1'b1), .AE_THRESH(1)) dutF (
      .clk   (clk),
      .reset (reset),
      .bus   (busF)
   );

   always #5 clk = ~clk;

   logic [7:0]  memS [4];
   logic [7:0]  memF [4];
   logic [7:0]  ramOutS;
   logic [7:0]  ramOutF;
   logic [7:0]  nextData;
   logic [AW:0] wrS;
   logic [AW:0] wrF;
   logic [7:0]  qS [$];
   logic [7:0]  qF [$];

   // Registered-read RAM: output holds while rd_en is low.
   always @(posedge clk) begin
      if (busS.rd_en === 1'b1) ramOutS <= memS[busS.rd_addr];
      if (busF.rd_en === 1'b1) ramOutF <= memF[busF.rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeS();
      memS[wrS[AW-1:0]] = nextData;
      qS.push_back(nextData);
      nextData++;
      wrS++;
      busS.wr_ptr = wrS;
   endtask

   task automatic writeF();
      memF[wrF[AW-1:0]] = nextData;
      qF.push_back(nextData);
      nextData++;
      wrF++;
      busF.wr_ptr = wrF;
   endtask

   task automatic clearWriters();
      wrS = '0;
      wrF = '0;
      busS.wr_ptr = '0;
      busF.wr_ptr = '0;
      busS.rd_req = 1'b0;
      busF.rd_req = 1'b0;
      qS.delete();
      qF.delete();
   endtask

   // Scoreboards: standard mode delivers on every dout_valid, FWFT delivers on each pop.
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset === 1'b0 && busS.dout_valid === 1'b1) begin
         e = (qS.size() != 0) ? 32'(qS.pop_front()) : 32'hDEAD_BEEF;
         check("std_data", 32'(ramOutS), e);
      end
      if (reset === 1'b0 && busF.dout_valid === 1'b1 && busF.rd_req === 1'b1) begin
         e = (qF.size() != 0) ? 32'(qF.pop_front()) : 32'hDEAD_BEEF;
         check("fwft_data", 32'(ramOutF), e);
      end
   end

   initial begin
      reset    = 1'b1;
      nextData = 8'h10;
      ramOutS  = '0;
      ramOutF  = '0;
      clearWriters();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_rdptr_s", busS.rd_ptr, 0);
      check("rst_empty_s", busS.empty, 1);
      check("rst_ae_s", busS.almost_empty, 1);
      check("rst_dv_s", busS.dout_valid, 0);
      check("rst_rden_s", busS.rd_en, 0);
      check("rst_uf_s", busS.underflow, 0);
      check("rst_rdptr_f", busF.rd_ptr, 0);
      check("rst_empty_f", busF.empty, 1);
      check("rst_dv_f", busF.dout_valid, 0);
      check("rst_rden_f", busF.rd_en, 0);
      check("rst_uf_f", busF.underflow, 0);

      // Standard mode: four words, rd_req held six cycles.
      tick();
      for (int i = 0; i < 4; i++) writeS();
      @(negedge clk);
      check("s_lvl4", busS.level, 4);
      check("s_ae_full", busS.almost_empty, 0);
      check("s_rden_idle", busS.rd_en, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         busS.rd_req = 1'b1;
         @(negedge clk);
         check("s_rden", busS.rd_en, 32'(i < 4));
         if (i < 4) check("s_addr", busS.rd_addr, i);
         check("s_dv", busS.dout_valid, 32'(i >= 1 && i <= 4));
         check("s_lvl", busS.level, (i < 4) ? 4 - i : 0);
         check("s_ae", busS.almost_empty, 32'(((i < 4) ? 4 - i : 0) <= 1));
         check("s_empty", busS.empty, 32'(i >= 4));
      end
      tick();
      busS.rd_req = 1'b0;
      @(negedge clk);
      check("s_sb_drained", qS.size(), 0);
      check("s_rdptr4", busS.rd_ptr, 4);

      // FWFT: single write falls through without a request.
      tick();
      writeF();
      @(negedge clk);
      check("f_rden_t", busF.rd_en, 1);
      check("f_addr_t", busF.rd_addr, 0);
      check("f_dv_t", busF.dout_valid, 0);
      tick();
      @(negedge clk);
      check("f_dv_t1", busF.dout_valid, 1);
      check("f_empty_t1", busF.empty, 0);
      check("f_lvl_t1", busF.level, 1);
      check("f_rden_t1", busF.rd_en, 0);
      tick();
      busF.rd_req = 1'b1;
      @(negedge clk);
      check("f_dv_held", busF.dout_valid, 1);
      tick();
      busF.rd_req = 1'b0;
      @(negedge clk);
      check("f_dv_popped", busF.dout_valid, 0);
      check("f_rdptr1", busF.rd_ptr, 1);
      check("f_empty_popped", busF.empty, 1);

      // FWFT streaming: four preloaded words, pops back-to-back.
      tick();
      for (int i = 0; i < 4; i++) writeF();
      @(negedge clk);
      check("fs_rden0", busF.rd_en, 1);
      check("fs_addr0", busF.rd_addr, 1);
      check("fs_lvl0", busF.level, 4);
      for (int i = 1; i <= 4; i++) begin
         tick();
         busF.rd_req = 1'b1;
         @(negedge clk);
         check("fs_dv", busF.dout_valid, 1);
         check("fs_rden", busF.rd_en, 32'(i < 4));
         if (i < 4) check("fs_addr", busF.rd_addr, (1 + i) % 4);
         check("fs_lvl", busF.level, 5 - i);
      end
      tick();
      busF.rd_req = 1'b0;
      @(negedge clk);
      check("fs_idle_dv", busF.dout_valid, 0);
      check("fs_idle_empty", busF.empty, 1);
      check("fs_rdptr5", busF.rd_ptr, 5);
      check("fs_sb_drained", qF.size(), 0);

      // Reset while a FWFT word is being presented.
      tick();
      for (int i = 0; i < 3; i++) writeF();
      tick();
      @(negedge clk);
      check("rm_dv_before", busF.dout_valid, 1);
      tick();
      reset = 1'b1;
      clearWriters();
      @(negedge clk);
      check("rm_rdptr", busF.rd_ptr, 0);
      check("rm_dv", busF.dout_valid, 0);
      check("rm_lvl", busF.level, 0);
      check("rm_rden", busF.rd_en, 0);
      tick();
      reset = 1'b0;

      // Wrap-around: ten write/read pairs through both controllers.
      for (int k = 0; k < 10; k++) begin
         tick();
         writeS();
         writeF();
         busS.rd_req = 1'b1;
         busF.rd_req = 1'b0;
         @(negedge clk);
         check("w_rdptr_s", busS.rd_ptr, k % 8);
         check("w_msb_s", busS.rd_ptr[AW], (k / 4) % 2);
         check("w_rdptr_f", busF.rd_ptr, k % 8);
         check("w_msb_f", busF.rd_ptr[AW], (k / 4) % 2);
         check("w_rden_s", busS.rd_en, 1);
         check("w_addr_s", busS.rd_addr, k % 4);
         check("w_rden_f", busF.rd_en, 1);
         check("w_addr_f", busF.rd_addr, k % 4);
         check("w_lvl_s", busS.level, 1);
         check("w_ae_s", busS.almost_empty, 1);
         check("w_lvl_f", busF.level, 1);
         check("w_ae_f", busF.almost_empty, 1);
         tick();
         busS.rd_req = 1'b0;
         busF.rd_req = 1'b1;
         @(negedge clk);
         check("w_lvl0_s", busS.level, 0);
         check("w_ae0_s", busS.almost_empty, 1);
         check("w_dv_f", busF.dout_valid, 1);
         check("w_lvlb_f", busF.level, 1);
      end
      tick();
      busF.rd_req = 1'b0;
      @(negedge clk);
      check("w_end_rdptr_s", busS.rd_ptr, 2);
      check("w_end_rdptr_f", busF.rd_ptr, 2);
      check("w_end_lvl_f", busF.level, 0);
      check("w_sb_s", qS.size(), 0);
      check("w_sb_f", qF.size(), 0);

      // Reads on an empty FIFO: ignored, optionally flagged.
      tick();
      busS.rd_req = 1'b1;
      busF.rd_req = 1'b1;
      @(negedge clk);
      check("u_rden_s", busS.rd_en, 0);
      check("u_rden_f", busF.rd_en, 0);
      tick();
      busS.rd_req = 1'b0;
      busF.rd_req = 1'b0;
      @(negedge clk);
      check("u_flag_s", busS.underflow, UF_EXP);
      check("u_flag_f", busF.underflow, UF_EXP);
      check("u_rdptr_s", busS.rd_ptr, 2);
      check("u_rdptr_f", busF.rd_ptr, 2);
      tick();
      writeS();
      writeF();
      busS.rd_req = 1'b1;
      @(negedge clk);
      tick();
      busS.rd_req = 1'b0;
      busF.rd_req = 1'b1;
      @(negedge clk);
      tick();
      busF.rd_req = 1'b0;
      @(negedge clk);
      check("u_sticky_s", busS.underflow, UF_EXP);
      check("u_sticky_f", busF.underflow, UF_EXP);
      check("u_rdptr3_s", busS.rd_ptr, 3);
      check("u_rdptr3_f", busF.rd_ptr, 3);
      tick();
      reset = 1'b1;
      clearWriters();
      @(negedge clk);
      check("u_clr_s", busS.underflow, 0);
      check("u_clr_f", busF.underflow, 0);
      tick();
      reset = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
